// File: rtl/arkanoid_key_ctrl.sv
// PS/2 Set-2 scan-code sequencer: decodes make/break/E0 sequences, tracks the
// paddle keys, arbitrates paddle direction and emits launch/pause/error pulses.
module arkanoid_key_ctrl #(
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       key_left,
  output logic       key_right,
  output logic [1:0] move_dir,
  output logic       launch_pulse,
  output logic       pause_pulse,
  output logic       seq_error
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          l_arrow, a_key, r_arrow, d_key, space_held, esc_held, last_right;
  logic          l_n, a_n, r_n, d_n, space_n, esc_n, last_right_n;
  logic          is_make, is_brk, is_ext, err, timeout;
  logic          left_n, right_n, ignored;

  assign ignored = (rx_data == 8'hFA) || (rx_data == 8'hAA) || (rx_data == 8'hEE) ||
                   (rx_data == 8'hFE) || (rx_data == 8'hE1);

  // Prefix parser; an illegal prefix restarts the parse with that same byte.
  always_comb begin
    state_n = state;
    is_make = 1'b0;
    is_brk  = 1'b0;
    is_ext  = 1'b0;
    err     = 1'b0;
    timeout = 1'b0;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_data == 8'hE0)      state_n = EXT;
          else if (rx_data == 8'hF0) state_n = BRK;
          else if (!ignored)         is_make = 1'b1;
        end
        EXT: begin
          if (rx_data == 8'hE0)      err = 1'b1;
          else if (rx_data == 8'hF0) state_n = EXT_BRK;
          else begin
            is_make = 1'b1;
            is_ext  = 1'b1;
            state_n = IDLE;
          end
        end
        default: begin
          if (rx_data == 8'hE0) begin
            err     = 1'b1;
            state_n = EXT;
          end else if (rx_data == 8'hF0) begin
            err     = 1'b1;
            state_n = BRK;
          end else begin
            is_brk  = 1'b1;
            is_ext  = (state == EXT_BRK);
            state_n = IDLE;
          end
        end
      endcase
    end else if (state != IDLE && cnt == CNT_LAST) begin
      timeout = 1'b1;
      err     = 1'b1;
      state_n = IDLE;
    end
  end

  // Held-key next state; a byte only ever touches one key.
  always_comb begin
    l_n     = l_arrow;
    a_n     = a_key;
    r_n     = r_arrow;
    d_n     = d_key;
    space_n = space_held;
    esc_n   = esc_held;
    if (is_make || is_brk) begin
      if (is_ext) begin
        if (rx_data == 8'h6B) l_n = is_make;
        if (rx_data == 8'h74) r_n = is_make;
      end else begin
        if (rx_data == 8'h1C) a_n     = is_make;
        if (rx_data == 8'h23) d_n     = is_make;
        if (rx_data == 8'h29) space_n = is_make;
        if (rx_data == 8'h76) esc_n   = is_make;
      end
    end
    left_n  = l_n | a_n;
    right_n = r_n | d_n;
    // Only a side going from released to held claims priority.
    last_right_n = last_right;
    if (left_n && !(l_arrow | a_key))       last_right_n = 1'b0;
    else if (right_n && !(r_arrow | d_key)) last_right_n = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      l_arrow      <= 1'b0;
      a_key        <= 1'b0;
      r_arrow      <= 1'b0;
      d_key        <= 1'b0;
      space_held   <= 1'b0;
      esc_held     <= 1'b0;
      last_right   <= 1'b0;
      key_left     <= 1'b0;
      key_right    <= 1'b0;
      move_dir     <= 2'b00;
      launch_pulse <= 1'b0;
      pause_pulse  <= 1'b0;
      seq_error    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= (rx_valid || timeout || state == IDLE) ? '0 : cnt + 1'b1;
      l_arrow    <= l_n;
      a_key      <= a_n;
      r_arrow    <= r_n;
      d_key      <= d_n;
      space_held <= space_n;
      esc_held   <= esc_n;
      last_right <= last_right_n;
      key_left   <= left_n;
      key_right  <= right_n;
      case ({right_n, left_n})
        2'b01:   move_dir <= 2'b01;
        2'b10:   move_dir <= 2'b10;
        2'b11:   move_dir <= last_right_n ? 2'b10 : 2'b01;
        default: move_dir <= 2'b00;
      endcase
      launch_pulse <= space_n && !space_held;
      pause_pulse  <= esc_n && !esc_held;
      seq_error    <= err;
    end
  end

endmodule

// File: tb/tb_arkanoid_key_ctrl.sv
// Directed bench for arkanoid_key_ctrl with a short timeout.
module tb_arkanoid_key_ctrl;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       key_left, key_right, launch_pulse, pause_pulse, seq_error;
  logic [1:0] move_dir;
  int         pass = 0, total = 0;
  int         launch_cnt = 0;

  arkanoid_key_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_left(key_left), .key_right(key_right), .move_dir(move_dir),
    .launch_pulse(launch_pulse), .pause_pulse(pause_pulse), .seq_error(seq_error)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (launch_pulse) launch_cnt++;

  // Drive one byte for one cycle; returns just after the capturing edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #2;
    total++; if ({key_left, key_right, move_dir, launch_pulse, pause_pulse, seq_error} !== 7'b0)
      $display("FAIL reset outs got %b exp 0", {key_left, key_right, move_dir, launch_pulse, pause_pulse, seq_error}); else pass++;
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_ext_left();
    send(8'hE0);
    total++; if (key_left !== 1'b0) $display("FAIL ext_prefix key_left got %b exp 0", key_left); else pass++;
    send(8'h6B);
    total++; if (key_left !== 1'b1) $display("FAIL ext_make key_left got %b exp 1", key_left); else pass++;
    total++; if (move_dir !== 2'b01) $display("FAIL ext_make move_dir got %b exp 01", move_dir); else pass++;
    send(8'hE0); send(8'hF0); send(8'h6B);
    total++; if (key_left !== 1'b0) $display("FAIL ext_brk key_left got %b exp 0", key_left); else pass++;
    total++; if (move_dir !== 2'b00) $display("FAIL ext_brk move_dir got %b exp 00", move_dir); else pass++;
  endtask

  task automatic test_arbitration();
    send(8'h1C);
    total++; if (move_dir !== 2'b01) $display("FAIL arb_a move_dir got %b exp 01", move_dir); else pass++;
    send(8'hE0); send(8'h74);
    total++; if ({key_left, key_right, move_dir} !== 4'b1110) $display("FAIL arb_both got %b exp 1110", {key_left, key_right, move_dir}); else pass++;
    send(8'hE0); send(8'hF0); send(8'h74);
    total++; if (move_dir !== 2'b01) $display("FAIL arb_rel_right move_dir got %b exp 01", move_dir); else pass++;
    send(8'h1C); send(8'h1C); send(8'h1C);
    total++; if (move_dir !== 2'b01) $display("FAIL arb_repeat move_dir got %b exp 01", move_dir); else pass++;
    send(8'h23);
    total++; if (move_dir !== 2'b10) $display("FAIL arb_d move_dir got %b exp 10", move_dir); else pass++;
    send(8'h1C); send(8'h1C);
    total++; if (move_dir !== 2'b10) $display("FAIL arb_typematic move_dir got %b exp 10", move_dir); else pass++;
    send(8'hF0); send(8'h23);
    total++; if ({key_right, move_dir} !== 3'b001) $display("FAIL arb_rel_d got %b exp 001", {key_right, move_dir}); else pass++;
    send(8'hF0); send(8'h1C);
    total++; if ({key_left, key_right, move_dir} !== 4'b0000) $display("FAIL arb_none got %b exp 0000", {key_left, key_right, move_dir}); else pass++;
  endtask

  task automatic test_launch();
    int start;
    start = launch_cnt;
    send(8'h29);
    total++; if (launch_pulse !== 1'b1) $display("FAIL launch_first got %b exp 1", launch_pulse); else pass++;
    @(posedge clk); #1;
    total++; if (launch_pulse !== 1'b0) $display("FAIL launch_width got %b exp 0", launch_pulse); else pass++;
    send(8'h29); send(8'h29);
    total++; if (launch_pulse !== 1'b0) $display("FAIL launch_typematic got %b exp 0", launch_pulse); else pass++;
    send(8'hF0); send(8'h29);
    total++; if (launch_pulse !== 1'b0) $display("FAIL launch_break got %b exp 0", launch_pulse); else pass++;
    send(8'h29);
    total++; if (launch_pulse !== 1'b1) $display("FAIL launch_again got %b exp 1", launch_pulse); else pass++;
    @(negedge clk); @(negedge clk);
    total++; if (launch_cnt - start !== 2) $display("FAIL launch_count got %0d exp 2", launch_cnt - start); else pass++;
    send(8'hF0); send(8'h29);
  endtask

  task automatic test_timeout();
    int errs, early;
    send(8'hE0);
    errs = 0; early = 0;
    for (int i = 0; i < T + 4; i++) begin
      @(posedge clk); #1;
      if (seq_error) begin errs++; if (i != T - 1) early++; end
    end
    total++; if (errs !== 1) $display("FAIL timeout_count got %0d exp 1", errs); else pass++;
    total++; if (early !== 0) $display("FAIL timeout_cycle got %0d off-cycle pulses exp 0", early); else pass++;
    send(8'h6B);
    total++; if ({key_left, move_dir} !== 3'b000) $display("FAIL timeout_idle got %b exp 000", {key_left, move_dir}); else pass++;
    // byte on the would-be timeout edge wins
    send(8'hE0);
    errs = 0;
    repeat (T - 1) begin @(posedge clk); #1; if (seq_error) errs++; end
    send(8'h6B);
    if (seq_error) errs++;
    total++; if (errs !== 0) $display("FAIL timeout_suppress errors got %0d exp 0", errs); else pass++;
    total++; if (key_left !== 1'b1) $display("FAIL timeout_suppress key_left got %b exp 1", key_left); else pass++;
    send(8'hE0); send(8'hF0); send(8'h6B);
  endtask

  task automatic test_illegal();
    send(8'hF0);
    total++; if (seq_error !== 1'b0) $display("FAIL illegal_first got %b exp 0", seq_error); else pass++;
    send(8'hF0);
    total++; if (seq_error !== 1'b1) $display("FAIL illegal_f0f0 got %b exp 1", seq_error); else pass++;
    send(8'h76);
    total++; if ({pause_pulse, seq_error} !== 2'b00) $display("FAIL illegal_brk76 got %b exp 00", {pause_pulse, seq_error}); else pass++;
    send(8'h76);
    total++; if (pause_pulse !== 1'b1) $display("FAIL pause_make got %b exp 1", pause_pulse); else pass++;
    send(8'hE0); send(8'hE0);
    total++; if (seq_error !== 1'b1) $display("FAIL illegal_e0e0 got %b exp 1", seq_error); else pass++;
    send(8'h6B);
    total++; if (key_left !== 1'b1) $display("FAIL illegal_restart key_left got %b exp 1", key_left); else pass++;
    send(8'hE0); send(8'hF0); send(8'h6B);
    send(8'hF0); send(8'h76);
  endtask

  task automatic test_reset_mid();
    send(8'hE0); send(8'h6B);
    total++; if ({key_left, move_dir} !== 3'b101) $display("FAIL mid_hold got %b exp 101", {key_left, move_dir}); else pass++;
    send(8'hE0); send(8'hF0);
    #2 resetn = 1'b0;
    #1;
    total++; if ({key_left, key_right, move_dir, launch_pulse, pause_pulse, seq_error} !== 7'b0)
      $display("FAIL mid_reset outs got %b exp 0", {key_left, key_right, move_dir, launch_pulse, pause_pulse, seq_error}); else pass++;
    @(negedge clk); resetn = 1'b1;
    send(8'h6B);
    total++; if ({key_left, move_dir, seq_error} !== 4'b0000) $display("FAIL mid_after got %b exp 0000", {key_left, move_dir, seq_error}); else pass++;
  endtask

  initial begin
    test_reset();
    test_ext_left();
    test_arbitration();
    test_launch();
    test_timeout();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
